frame_assembler_fifo: RTL and testbench

FRAME_ASSEMBLER_FIFO -- requirements
Module: frame_assembler_fifo

---
 rtl/frame_assembler_fifo.sv | 110 +++++++++++
 tb/tb_frame_assembler_fifo.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/frame_assembler_fifo.sv
// Frame assembler feeding a frame-wide FIFO: channel words build a frame, last_word commits it.
// Build option FRAME_MASK_EN stores a per-frame written-channel mask; otherwise the mask reads all ones.
module frame_assembler_fifo #(
  parameter int NUM_CH      = 8,
  parameter int WORD_W      = 16,
  parameter int FRAME_DEPTH = 16,
  localparam int PTR_W      = $clog2(FRAME_DEPTH),
  localparam int CH_W       = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  localparam int FRAME_W    = NUM_CH * WORD_W
) (
  input  logic               sample_clk,
  input  logic               reset_n,
  input  logic [WORD_W-1:0]  data_in,
  input  logic               done,
  input  logic [CH_W-1:0]    atmchsel,
  input  logic               last_word,
  input  logic [PTR_W:0]     threshold,
  input  logic               frame_pop,
  input  logic               clear_ovf,
  output logic [FRAME_W-1:0] frame_data_out,
  output logic [NUM_CH-1:0]  frame_valid_mask,
  output logic               fifo_ready,
  output logic [PTR_W:0]     fill_level,
  output logic               overflow
);

  logic [FRAME_W-1:0] asm_data;
  logic [FRAME_W-1:0] asm_data_next;
  logic [FRAME_W-1:0] mem [FRAME_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W:0]     thr_eff;
  logic               slot_ok;
  logic               commit;
  logic               full;
  logic               pop_ok;
  logic               drop;
  logic               push;

  assign slot_ok = done && (int'(atmchsel) < NUM_CH);
  assign commit  = done && last_word;
  assign full    = (fill_level == (PTR_W+1)'(FRAME_DEPTH));
  assign pop_ok  = frame_pop && (fill_level != '0);
  // A pop on the same edge frees the slot, so a commit into a full FIFO is still accepted.
  assign drop    = commit && full && !pop_ok;
  assign push    = commit && !drop;

  always_comb begin
    asm_data_next = asm_data;
    if (slot_ok) asm_data_next[int'(atmchsel)*WORD_W +: WORD_W] = data_in;
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_data       <= '0;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      fill_level     <= '0;
      overflow       <= 1'b0;
      frame_data_out <= '0;
    end else begin
      asm_data <= commit ? '0 : asm_data_next;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok) begin
        rd_ptr         <= rd_ptr + PTR_W'(1);
        frame_data_out <= mem[rd_ptr];
      end
      if (push && !pop_ok)      fill_level <= fill_level + (PTR_W+1)'(1);
      else if (pop_ok && !push) fill_level <= fill_level - (PTR_W+1)'(1);
      if (drop)           overflow <= 1'b1;
      else if (clear_ovf) overflow <= 1'b0;
    end
  end

  // Frame storage carries no reset; only pointers and fill qualify its contents.
  always_ff @(posedge sample_clk) begin
    if (push) mem[wr_ptr] <= asm_data_next;
  end

`ifdef FRAME_MASK_EN
  logic [NUM_CH-1:0] asm_mask;
  logic [NUM_CH-1:0] asm_mask_next;
  logic [NUM_CH-1:0] mem_mask [FRAME_DEPTH];

  always_comb begin
    asm_mask_next = asm_mask;
    if (slot_ok) asm_mask_next[int'(atmchsel)] = 1'b1;
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      asm_mask         <= '0;
      frame_valid_mask <= '0;
    end else begin
      asm_mask <= commit ? '0 : asm_mask_next;
      if (pop_ok) frame_valid_mask <= mem_mask[rd_ptr];
    end
  end

  always_ff @(posedge sample_clk) begin
    if (push) mem_mask[wr_ptr] <= asm_mask_next;
  end
`else
  assign frame_valid_mask = '1;
`endif

  assign thr_eff    = (threshold == '0) ? (PTR_W+1)'(1) : threshold;
  assign fifo_ready = (threshold <= (PTR_W+1)'(FRAME_DEPTH)) && (fill_level >= thr_eff);

endmodule

// File: tb/tb_frame_assembler_fifo.sv
// Bench for frame_assembler_fifo: vector table, directed corner sequences, and randomized
// traffic checked against a queue-based frame model.
module tb_frame_assembler_fifo;
  localparam int NUM_CH      = 8;
  localparam int WORD_W      = 16;
  localparam int FRAME_DEPTH = 16;
  localparam int PTR_W       = 4;
  localparam int CH_W        = 3;
  localparam int FW          = NUM_CH * WORD_W;

  logic              sample_clk = 1'b0;
  logic              reset_n    = 1'b0;
  logic [WORD_W-1:0] data_in    = '0;
  logic              done       = 1'b0;
  logic [CH_W-1:0]   atmchsel   = '0;
  logic              last_word  = 1'b0;
  logic [PTR_W:0]    threshold  = '0;
  logic              frame_pop  = 1'b0;
  logic              clear_ovf  = 1'b0;
  logic [FW-1:0]     frame_data_out;
  logic [NUM_CH-1:0] frame_valid_mask;
  logic              fifo_ready;
  logic [PTR_W:0]    fill_level;
  logic              overflow;

  frame_assembler_fifo #(.NUM_CH(NUM_CH), .WORD_W(WORD_W), .FRAME_DEPTH(FRAME_DEPTH)) dut (
    .sample_clk(sample_clk), .reset_n(reset_n), .data_in(data_in), .done(done),
    .atmchsel(atmchsel), .last_word(last_word), .threshold(threshold),
    .frame_pop(frame_pop), .clear_ovf(clear_ovf), .frame_data_out(frame_data_out),
    .frame_valid_mask(frame_valid_mask), .fifo_ready(fifo_ready),
    .fill_level(fill_level), .overflow(overflow)
  );

  always #5 sample_clk = ~sample_clk;

  typedef struct { logic [FW-1:0] data; logic [NUM_CH-1:0] mask; } frame_t;
  typedef struct { bit d; int ch; logic [15:0] data; bit last; bit pop; int thr; int efill; bit eready; } vec_t;

  frame_t            q[$];
  vec_t              tbl[$];
  logic [FW-1:0]     m_asm, m_out;
  logic [NUM_CH-1:0] m_amask, m_omask;
  bit                m_ovf;
  int                thr;
  int                n_vec, n_err;

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_asm = '0; m_amask = '0; m_out = '0; m_omask = '0; m_ovf = 0;
  endtask

  // Pop first, then commit: a pop on a full queue makes room for the same-edge commit.
  task automatic model_edge(input bit d, input int ch, input logic [15:0] data,
                            input bit last, input bit pop, input bit clr);
    bit drop;
    drop = 0;
    if (pop && q.size() > 0) begin
      frame_t f;
      f = q.pop_front();
      m_out = f.data; m_omask = f.mask;
    end
    if (d) begin
      if (ch < NUM_CH) begin
        m_asm[ch*WORD_W +: WORD_W] = data;
        m_amask[ch] = 1'b1;
      end
      if (last) begin
        if (q.size() < FRAME_DEPTH) q.push_back('{m_asm, m_amask});
        else drop = 1;
        m_asm = '0; m_amask = '0;
      end
    end
    if (drop) m_ovf = 1;
    else if (clr) m_ovf = 0;
  endtask

  task automatic check_all();
    int  thr_e;
    bit  exp_r;
    thr_e = (thr == 0) ? 1 : thr;
    exp_r = (thr <= FRAME_DEPTH) && (q.size() >= thr_e);
    chk("fill_level", fill_level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("fifo_ready", fifo_ready, exp_r);
    chk("frame_data_out", frame_data_out, m_out);
`ifdef FRAME_MASK_EN
    chk("frame_valid_mask", frame_valid_mask, m_omask);
`else
    chk("frame_valid_mask", frame_valid_mask, {NUM_CH{1'b1}});
`endif
  endtask

  task automatic step(input bit d, input int ch, input logic [15:0] data,
                      input bit last, input bit pop, input bit clr);
    done = d; atmchsel = CH_W'(ch); data_in = data; last_word = last;
    frame_pop = pop; clear_ovf = clr; threshold = (PTR_W+1)'(thr);
    @(posedge sample_clk);
    model_edge(d, ch, data, last, pop, clr);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    done = 0; frame_pop = 0; clear_ovf = 0; last_word = 0;
    reset_n = 0;
    #3;
    model_reset();
    check_all();
    @(posedge sample_clk);
    #1;
    reset_n = 1;
  endtask

  initial begin
    n_vec = 0; n_err = 0; thr = 1;

    for (int i = 0; i < 8; i++) tbl.push_back('{1, i, 16'hFFFF, i == 7, 0, 1, (i == 7) ? 1 : 0, i == 7});
    tbl.push_back('{0, 0, 16'h0, 0, 1, 1, 0, 0});
    for (int k = 0; k < 4; k++) tbl.push_back('{1, 0, 16'(k + 1), 1, 0, 4, k + 1, k == 3});
    for (int k = 0; k < 4; k++) tbl.push_back('{0, 0, 16'h0, 0, 1, 4, 3 - k, 0});
    tbl.push_back('{0, 0, 16'h0, 0, 1, 4, 0, 0});

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      thr = tbl[i].thr;
      step(tbl[i].d, tbl[i].ch, tbl[i].data, tbl[i].last, tbl[i].pop, 0);
      chk("tbl_fill", fill_level, tbl[i].efill);
      chk("tbl_ready", fifo_ready, tbl[i].eready);
      if (i == 8) begin
        chk("all_ones_frame", frame_data_out, {8{16'hFFFF}});
        chk("all_ones_mask", frame_valid_mask, 8'hFF);
      end
    end
    chk("empty_pop_hold", frame_data_out[15:0], 16'h0004);

    // Sparse frame: only ch2 and ch5 written
    thr = 1;
    step(1, 2, 16'hAAAA, 0, 0, 0);
    step(1, 5, 16'hBBBB, 1, 0, 0);
    step(0, 0, 16'h0, 0, 1, 0);
    chk("sparse_data", frame_data_out, 128'h0000_0000_BBBB_0000_0000_AAAA_0000_0000);
`ifdef FRAME_MASK_EN
    chk("sparse_mask", frame_valid_mask, 8'h24);
`else
    chk("sparse_mask", frame_valid_mask, 8'hFF);
`endif

    // Overflow on the 17th frame, then drain in order and clear
    for (int k = 0; k < 16; k++) step(1, 0, 16'(16'h0100 + k), 1, 0, 0);
    step(1, 0, 16'hDEAD, 1, 0, 0);
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_fill", fill_level, 5'd16);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 16'h0, 0, 1, 0);
      chk("ovf_order", frame_data_out[15:0], 16'(16'h0100 + k));
    end
    step(0, 0, 16'h0, 0, 0, 1);
    chk("ovf_clear", overflow, 1'b0);

    // Full FIFO: commit and pop on the same edge
    for (int k = 0; k < 16; k++) step(1, 0, 16'(16'h0200 + k), 1, 0, 0);
    step(1, 0, 16'h02FF, 1, 1, 0);
    chk("full_cp_fill", fill_level, 5'd16);
    chk("full_cp_ovf", overflow, 1'b0);
    for (int k = 0; k < 16; k++) step(0, 0, 16'h0, 0, 1, 0);
    chk("full_cp_last", frame_data_out[15:0], 16'h02FF);

    // Reset mid-frame discards the partial assembly
    step(1, 0, 16'h1234, 0, 0, 0);
    do_reset();
    step(1, 3, 16'h5555, 1, 0, 0);
    step(0, 0, 16'h0, 0, 1, 0);
    chk("midreset_ch0", frame_data_out[15:0], 16'h0000);
    chk("midreset_ch3", frame_data_out[63:48], 16'h5555);

    // Randomized traffic against the queue model
    for (int n = 0; n < 600; n++) begin
      bit d, last, pop, clr;
      d    = ($urandom_range(0, 9) < 7);
      last = ($urandom_range(0, 3) == 0);
      pop  = ($urandom_range(0, 9) < 3);
      clr  = ($urandom_range(0, 19) == 0);
      thr  = $urandom_range(0, 20);
      step(d, $urandom_range(0, NUM_CH - 1), 16'($urandom), last, pop, clr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
